seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the board's multiplexed 4-digit 7-segment driver. Samples the active-low anode/segment lines once they are stable and recovers each digit's hex value. Commits a full 4-digit frame and reports the two decimal pairs (digits 1:0 and 3:2) as binary numbers. Used in benches and on-board self-check to read back what the display logic actually shows.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_scan_decoder_if.sv | 29 ++
 rtl/seg7_glyph_decode.sv | 25 ++
 rtl/seg7_scan_decoder.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-high glyph table, blank pattern, digit count
// and the pair arithmetic used when a frame is committed.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [3:0] hex_t;

    // Index is the hex value, entry is the active-high {g,f,e,d,c,b,a} pattern
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] pair_value(input hex_t tens, input hex_t ones);
        return 8'(tens) * 8'd10 + 8'(ones);
    endfunction

    function automatic logic pair_is_decimal(input logic [1:0] vld, input hex_t tens,
                                             input hex_t ones);
        return (&vld) && (tens <= 4'd9) && (ones <= 4'd9);
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-line inputs and decoded results of the 7-segment scan decoder.
interface seg7_scan_decoder_if;

    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [7:0]  pair_lo;
    logic [7:0]  pair_hi;
    logic [1:0]  pair_ok;
    logic        frame_valid;
    logic        scan_err;
    logic [3:0]  glyph_err;
    logic [3:0]  dp_out;

    modport master (
        output an, seg, dp,
        input  digits, digit_valid, pair_lo, pair_hi, pair_ok,
        input  frame_valid, scan_err, glyph_err, dp_out
    );

    modport slave (
        input  an, seg, dp,
        output digits, digit_valid, pair_lo, pair_hi, pair_ok,
        output frame_valid, scan_err, glyph_err, dp_out
    );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational lookup of an active-high segment pattern into a hex value,
// flagging legal glyphs and the all-off blank pattern.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic       blank,
    output hex_t       value
);

    always_comb begin
        legal = 1'b0;
        value = '0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPH_TABLE[i]) begin
                legal = 1'b1;
                value = 4'(i);
            end
        end
    end

    assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed 4-digit active-low 7-segment display into hex digits and
// decimal pairs. Define SEG7_DP_CAPTURE_EN to also track and capture decimal points.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  logic              mclk,
    input  logic              rst_n,
    seg7_scan_decoder_if.slave bus
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [11:0] snap, snap_q, snap_d;
    logic [7:0]  cnt_q, cnt_d;

    hex_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] shadow_vld_q, shadow_vld_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;

    logic [15:0] digits_q, digits_d;
    logic [3:0]  digit_valid_q, digit_valid_d;
    logic [7:0]  pair_lo_q, pair_lo_d;
    logic [7:0]  pair_hi_q, pair_hi_d;
    logic [1:0]  pair_ok_q, pair_ok_d;
    logic        frame_valid_q, frame_valid_d;
    logic        scan_err_q, scan_err_d;
    logic [3:0]  glyph_err_q, glyph_err_d;

    logic       same, sample, commit, sel_hit;
    logic [1:0] sel_k;
    logic [6:0] glyph_pat;
    logic       dec_legal, dec_blank;
    hex_t       dec_value;

`ifdef SEG7_DP_CAPTURE_EN
    localparam logic SNAP_DP_RST = 1'b1;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [3:0]            dp_out_q, dp_out_d;
    assign snap = {an_q, seg_q, dp_q};
`else
    localparam logic SNAP_DP_RST = 1'b0;
    logic dp_unused;
    assign dp_unused = bus.dp;
    assign snap      = {an_q, seg_q, 1'b0};
`endif

    assign glyph_pat = ~seg_q;

    seg7_glyph_decode u_glyph_decode (
        .pattern (glyph_pat),
        .legal   (dec_legal),
        .blank   (dec_blank),
        .value   (dec_value)
    );

    always_comb begin
        an_d  = bus.an;
        seg_d = bus.seg;
        snap_d = snap;

        // Sample fires once, on the transition of the counter into saturation
        same   = (snap == snap_q);
        sample = same && (cnt_q == CNT_MAX - 8'd1);
        if (!same)
            cnt_d = '0;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 8'd1;

        sel_hit = 1'b1;
        sel_k   = 2'd0;
        unique case (an_q)
            4'b1110: sel_k = 2'd0;
            4'b1101: sel_k = 2'd1;
            4'b1011: sel_k = 2'd2;
            4'b0111: sel_k = 2'd3;
            default: sel_hit = 1'b0;
        endcase

        commit        = (seen_q == '1);
        shadow_d      = shadow_q;
        shadow_vld_d  = shadow_vld_q;
        seen_d        = commit ? '0 : seen_q;
        glyph_err_d   = '0;
        scan_err_d    = 1'b0;
        frame_valid_d = commit;
        digits_d      = digits_q;
        digit_valid_d = digit_valid_q;
        pair_lo_d     = pair_lo_q;
        pair_hi_d     = pair_hi_q;
        pair_ok_d     = pair_ok_q;
`ifdef SEG7_DP_CAPTURE_EN
        dp_d        = bus.dp;
        shadow_dp_d = shadow_dp_q;
        dp_out_d    = commit ? shadow_dp_q : dp_out_q;
`endif

        if (sample && sel_hit) begin
            shadow_d[sel_k]     = dec_legal ? dec_value : '0;
            shadow_vld_d[sel_k] = dec_legal;
            seen_d[sel_k]       = 1'b1;
            glyph_err_d[sel_k]  = !dec_legal && !dec_blank;
`ifdef SEG7_DP_CAPTURE_EN
            shadow_dp_d[sel_k]  = ~dp_q;
`endif
        end
        if (sample && !sel_hit && (an_q != 4'hF))
            scan_err_d = 1'b1;

        if (commit) begin
            digits_d      = shadow_q;
            digit_valid_d = shadow_vld_q;
            pair_lo_d     = pair_value(shadow_q[1], shadow_q[0]);
            pair_hi_d     = pair_value(shadow_q[3], shadow_q[2]);
            pair_ok_d[0]  = pair_is_decimal(shadow_vld_q[1:0], shadow_q[1], shadow_q[0]);
            pair_ok_d[1]  = pair_is_decimal(shadow_vld_q[3:2], shadow_q[3], shadow_q[2]);
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            snap_q        <= {4'hF, 7'h7F, SNAP_DP_RST};
            cnt_q         <= '0;
            shadow_q      <= '0;
            shadow_vld_q  <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            digit_valid_q <= '0;
            pair_lo_q     <= '0;
            pair_hi_q     <= '0;
            pair_ok_q     <= '0;
            frame_valid_q <= 1'b0;
            scan_err_q    <= 1'b0;
            glyph_err_q   <= '0;
        end else begin
            an_q          <= an_d;
            seg_q         <= seg_d;
            snap_q        <= snap_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            shadow_vld_q  <= shadow_vld_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            digit_valid_q <= digit_valid_d;
            pair_lo_q     <= pair_lo_d;
            pair_hi_q     <= pair_hi_d;
            pair_ok_q     <= pair_ok_d;
            frame_valid_q <= frame_valid_d;
            scan_err_q    <= scan_err_d;
            glyph_err_q   <= glyph_err_d;
        end
    end

`ifdef SEG7_DP_CAPTURE_EN
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q        <= 1'b1;
            shadow_dp_q <= '0;
            dp_out_q    <= '0;
        end else begin
            dp_q        <= dp_d;
            shadow_dp_q <= shadow_dp_d;
            dp_out_q    <= dp_out_d;
        end
    end
    assign bus.dp_out = dp_out_q;
`else
    assign bus.dp_out = 4'b0000;
`endif

    assign bus.digits      = digits_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.pair_lo     = pair_lo_q;
    assign bus.pair_hi     = pair_hi_q;
    assign bus.pair_ok     = pair_ok_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.scan_err    = scan_err_q;
    assign bus.glyph_err   = glyph_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed display scans plus randomized traffic,
// checked every cycle against a run-length/table behavioural model.
module tb_seg7_scan_decoder;

    localparam int S = 4;
    localparam logic [6:0] GL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
`ifdef SEG7_DP_CAPTURE_EN
    localparam logic [11:0] IDLE_SNAP = {4'hF, 7'h7F, 1'b1};
`else
    localparam logic [11:0] IDLE_SNAP = {4'hF, 7'h7F, 1'b0};
`endif

    logic mclk  = 1'b0;
    logic rst_n = 1'b1;
    int n_checks = 0;
    int n_errs   = 0;
    int frames = 0, scans = 0, glyph_pulses = 0;
    logic [3:0] glyph_acc = '0;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 mclk = ~mclk;

    // Model state: shadow digits plus the expected registered outputs
    logic [11:0] m_prev, m_pend_x;
    int          m_run;
    bit          m_pend;
    int          m_sh [4];
    logic [3:0]  m_vld, m_dp, m_seen;
    logic [15:0] e_digits;
    logic [3:0]  e_dv, e_glyph, e_dpout;
    logic [7:0]  e_lo, e_hi;
    logic [1:0]  e_ok;
    logic        e_frame, e_scan;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [11:0] snap_now();
`ifdef SEG7_DP_CAPTURE_EN
        return {bus.an, bus.seg, bus.dp};
`else
        return {bus.an, bus.seg, 1'b0};
`endif
    endfunction

    function automatic int lookup(input logic [6:0] pat);
        int r = -1;
        for (int i = 0; i < 16; i++) if (GL[i] == pat) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_prev = IDLE_SNAP; m_run = 2; m_pend = 0; m_pend_x = '0;
        for (int i = 0; i < 4; i++) m_sh[i] = 0;
        m_vld = '0; m_dp = '0; m_seen = '0;
        e_digits = '0; e_dv = '0; e_glyph = '0; e_dpout = '0;
        e_lo = '0; e_hi = '0; e_ok = '0; e_frame = 0; e_scan = 0;
    endtask

    task automatic model_step();
        logic [3:0]  an;
        logic [6:0]  pat;
        logic [11:0] x;
        int k, val;
        e_glyph = '0; e_scan = 0; e_frame = 0;
        if (m_seen == 4'hF) begin
            e_digits = {4'(m_sh[3]), 4'(m_sh[2]), 4'(m_sh[1]), 4'(m_sh[0])};
            e_dv     = m_vld;
            e_lo     = 8'(m_sh[1] * 10 + m_sh[0]);
            e_hi     = 8'(m_sh[3] * 10 + m_sh[2]);
            e_ok[0]  = m_vld[0] && m_vld[1] && m_sh[0] <= 9 && m_sh[1] <= 9;
            e_ok[1]  = m_vld[2] && m_vld[3] && m_sh[2] <= 9 && m_sh[3] <= 9;
`ifdef SEG7_DP_CAPTURE_EN
            e_dpout  = m_dp;
`endif
            e_frame  = 1;
            m_seen   = '0;
        end
        if (m_pend) begin
            an  = m_pend_x[11:8];
            pat = ~m_pend_x[7:1];
            if ($countones(~an) == 1) begin
                k = 0;
                for (int i = 0; i < 4; i++) if (!an[i]) k = i;
                val = lookup(pat);
                m_sh[k]  = (val < 0) ? 0 : val;
                m_vld[k] = (val >= 0);
                if (val < 0 && pat != 7'h00) e_glyph[k] = 1'b1;
                m_dp[k]   = ~m_pend_x[0];
                m_seen[k] = 1'b1;
            end else if (an != 4'hF) begin
                e_scan = 1;
            end
        end
        // A sample is taken once a value has been seen on S+1 consecutive edges
        x = snap_now();
        if (x == m_prev) m_run++; else m_run = 1;
        if (m_run > 1000) m_run = 1000;
        m_prev   = x;
        m_pend   = (m_run == S + 1);
        m_pend_x = x;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge mclk or negedge rst_n);
            if (!rst_n) model_reset(); else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge mclk);
            check("digits",      32'(bus.digits),      32'(e_digits));
            check("digit_valid", 32'(bus.digit_valid), 32'(e_dv));
            check("pair_lo",     32'(bus.pair_lo),     32'(e_lo));
            check("pair_hi",     32'(bus.pair_hi),     32'(e_hi));
            check("pair_ok",     32'(bus.pair_ok),     32'(e_ok));
            check("frame_valid", 32'(bus.frame_valid), 32'(e_frame));
            check("scan_err",    32'(bus.scan_err),    32'(e_scan));
            check("glyph_err",   32'(bus.glyph_err),   32'(e_glyph));
            check("dp_out",      32'(bus.dp_out),      32'(e_dpout));
            if (bus.frame_valid === 1'b1) frames++;
            if (bus.scan_err === 1'b1) scans++;
            if (bus.glyph_err !== 4'b0000) glyph_pulses++;
            glyph_acc = glyph_acc | bus.glyph_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int cyc);
        bus.an = a; bus.seg = s; bus.dp = d;
        repeat (cyc) @(posedge mclk);
        #2;
    endtask

    task automatic idle(input int cyc);
        drive(4'hF, 7'h7F, 1'b1, cyc);
    endtask

    task automatic show(input int k, input logic [3:0] v, input logic d, input int cyc);
        logic [3:0] a;
        a = ~(4'b0001 << k);
        drive(a, ~GL[v], d, cyc);
    endtask

    task automatic scan(input logic [15:0] val, input logic [3:0] dpl, input int cyc);
        for (int k = 0; k < 4; k++) show(k, val[4*k +: 4], dpl[k], cyc);
    endtask

    task automatic pulse_reset();
        bus.an = 4'hF; bus.seg = 7'h7F; bus.dp = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge mclk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int f0, s0, hold;
        logic [15:0] v;
        logic [3:0]  dpl, want_dp;
        bus.an = 4'hF; bus.seg = 7'h7F; bus.dp = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge mclk);
        #2;
        check("rst_digits", 32'(bus.digits), 32'h0);
        check("rst_frame",  32'(bus.frame_valid), 32'h0);
        check("rst_pairs",  32'({bus.pair_hi, bus.pair_lo, bus.pair_ok}), 32'h0);
        check("rst_errs",   32'({bus.scan_err, bus.glyph_err, bus.dp_out, bus.digit_valid}), 32'h0);
        rst_n = 1'b1;
        idle(6);

        // "2107" scanned with 20-cycle dwell
        f0 = frames;
        scan(16'h2107, 4'hF, 20);
        idle(4);
        check("a_frames",  32'(frames - f0), 32'd1);
        check("a_digits",  32'(bus.digits), 32'h2107);
        check("a_pair_lo", 32'(bus.pair_lo), 32'd7);
        check("a_pair_hi", 32'(bus.pair_hi), 32'd21);
        check("a_pair_ok", 32'(bus.pair_ok), 32'd3);
        check("pin_model_digits", 32'(e_digits), 32'h2107);
        check("pin_model_hi",     32'(e_hi), 32'd21);

        // Digit 0 held too briefly: no frame until a later scan covers it
        pulse_reset();
        idle(4);
        f0 = frames;
        show(0, 4'h1, 1'b1, 3);
        show(1, 4'h2, 1'b1, 20);
        show(2, 4'h3, 1'b1, 20);
        show(3, 4'h4, 1'b1, 20);
        idle(4);
        check("b_no_frame", 32'(frames - f0), 32'd0);
        scan(16'h4321, 4'hF, 20);
        idle(4);
        check("b_frames", 32'(frames - f0), 32'd1);
        check("b_digits", 32'(bus.digits), 32'h4321);

        // Illegal pattern on digit 2
        pulse_reset();
        idle(4);
        f0 = frames; s0 = glyph_pulses; glyph_acc = '0;
        show(0, 4'h4, 1'b1, 20);
        show(1, 4'h3, 1'b1, 20);
        drive(4'b1011, 7'b0101010, 1'b1, 20);
        show(3, 4'h1, 1'b1, 20);
        idle(4);
        check("c_glyph_bits",   32'(glyph_acc), 32'h4);
        check("c_glyph_pulses", 32'(glyph_pulses - s0), 32'd1);
        check("c_frames",       32'(frames - f0), 32'd1);
        check("c_digit_valid",  32'(bus.digit_valid), 32'hB);
        check("c_pair_ok",      32'(bus.pair_ok), 32'd1);
        check("c_pair_hi",      32'(bus.pair_hi), 32'd10);
        check("c_pair_lo",      32'(bus.pair_lo), 32'd34);
        check("c_digits",       32'(bus.digits), 32'h1034);
        check("pin_model_ok",   32'(e_ok), 32'd1);

        // Two anodes low together
        s0 = scans; f0 = frames;
        drive(4'b1100, 7'h40, 1'b1, 10);
        idle(6);
        check("d_scan_pulses", 32'(scans - s0), 32'd1);
        check("d_frames",      32'(frames - f0), 32'd0);
        check("d_digits",      32'(bus.digits), 32'h1034);

        // "0F0A": hex digits above 9 break decimal validity
        f0 = frames;
        scan(16'h0F0A, 4'hF, 20);
        idle(4);
        check("e_frames",  32'(frames - f0), 32'd1);
        check("e_pair_lo", 32'(bus.pair_lo), 32'd10);
        check("e_pair_hi", 32'(bus.pair_hi), 32'd15);
        check("e_pair_ok", 32'(bus.pair_ok), 32'd0);
        check("e_valid",   32'(bus.digit_valid), 32'hF);
        check("pin_model_lo", 32'(e_lo), 32'd10);

        // Reset after three digits, then a full rescan with dp on digit 1
        f0 = frames;
        show(0, 4'h6, 1'b1, 20);
        show(1, 4'h7, 1'b1, 20);
        show(2, 4'h8, 1'b1, 20);
        pulse_reset();
        idle(4);
        show(0, 4'h6, 1'b1, 20);
        show(1, 4'h7, 1'b0, 20);
        show(2, 4'h8, 1'b1, 20);
        check("f_partial", 32'(frames - f0), 32'd0);
        show(3, 4'h9, 1'b1, 20);
        idle(4);
`ifdef SEG7_DP_CAPTURE_EN
        want_dp = 4'b0010;
`else
        want_dp = 4'b0000;
`endif
        check("f_frames", 32'(frames - f0), 32'd1);
        check("f_digits", 32'(bus.digits), 32'h9876);
        check("f_dp_out", 32'(bus.dp_out), 32'(want_dp));

        // Randomized scans: short dwells, garbage, idle gaps and random dp
        for (int it = 0; it < 40; it++) begin
            v   = 16'($urandom);
            dpl = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                hold = $urandom_range(2, 9);
                case ($urandom_range(0, 9))
                    0:       drive(4'($urandom), 7'($urandom), dpl[k], hold);
                    1:       idle(hold);
                    default: show(k, v[4*k +: 4], dpl[k], hold);
                endcase
            end
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
